// File: rtl/car_sensor_filter.sv
// Car sensor conditioning: 2-FF synchroniser, debounce qualification in both
// directions, and a hold timer that keeps the request alive after a release.
// Produces a clean request level, a one-cycle arrival pulse and a saturating
// arrival count.
module car_sensor_filter #(
  parameter int DB_CYCLES   = 50000,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_in,
  output logic       is_car,
  output logic       car_pulse,
  output logic [7:0] car_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    QUAL_ON,
    PRESENT,
    QUAL_OFF,
    HOLD
  } state_t;

  // Counter values reached on the last qualifying sample of each phase.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  // With a one-sample debounce there is nothing to qualify: levels are
  // accepted on the first synced sample.
  localparam bit DB_ONE = (DB_CYCLES == 1);

  logic             s_meta;
  logic             s_sync;
  state_t           state;
  logic             from_hold;
  logic [CNT_W-1:0] cnt;
  logic             arrive;

  // Two-stage synchroniser for the asynchronous sensor input.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // two stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
    end else begin
      s_meta <= sensor_in;
      s_sync <= s_meta;
    end
  end

  // An accepted arrival: the last qualifying high sample, or the first high
  // sample when no qualification is needed.
  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned and infers a latch.
  always_comb begin
    arrive = 1'b0;
    if (s_sync) begin
      if (state == QUAL_ON && cnt == DB_LAST)
        arrive = 1'b1;
      else if (DB_ONE && (state == IDLE || state == HOLD))
        arrive = 1'b1;
    end
  end

  // Debounce / hold state machine with registered outputs. One counter serves
  // both as the qualification counter and the hold timer, since they are
  // never needed in the same state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      from_hold <= 1'b0;
      cnt       <= '0;
      is_car    <= 1'b0;
      car_pulse <= 1'b0;
      car_cnt   <= 8'd0;
    end else begin
      car_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (s_sync) begin
            state     <= QUAL_ON;
            from_hold <= 1'b0;
            cnt       <= CNT_W'(1);
          end
        end

        QUAL_ON: begin
          if (s_sync) begin
            cnt <= cnt + CNT_W'(1);
          end else if (from_hold) begin
            // A glitch while holding: go back and restart the hold period.
            state <= HOLD;
            cnt   <= '0;
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end

        PRESENT: begin
          if (!s_sync) begin
            if (DB_ONE) begin
              state <= HOLD;
              cnt   <= '0;
            end else begin
              state <= QUAL_OFF;
              cnt   <= CNT_W'(1);
            end
          end
        end

        QUAL_OFF: begin
          if (s_sync) begin
            // Release bounce: the car never left, so no new arrival.
            state <= PRESENT;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        HOLD: begin
          if (s_sync) begin
            state     <= QUAL_ON;
            from_hold <= 1'b1;
            cnt       <= CNT_W'(1);
          end else if (cnt == HOLD_LAST) begin
            state  <= IDLE;
            cnt    <= '0;
            is_car <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      // An arrival overrides whatever the state decode above chose.
      if (arrive) begin
        state     <= PRESENT;
        cnt       <= '0;
        is_car    <= 1'b1;
        car_pulse <= 1'b1;
        if (car_cnt != 8'hFF)
          car_cnt <= car_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_car_sensor_filter.sv
// Bench for car_sensor_filter: a table of reset/press/bounce vectors,
// hand-written hold, re-arrival, saturation and reset sequences, then random
// sensor traffic against a run-length reference model. A second instance with
// a one-sample debounce rides along on the same stimulus.
module tb_car_sensor_filter;

  localparam int DB    = 4;
  localparam int HOLD  = 10;
  localparam int CW    = 8;
  localparam int DB1   = 1;
  localparam int HOLD1 = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor_in = 1'b0;
  logic       is_car, car_pulse;
  logic [7:0] car_cnt;
  logic       is_car1, car_pulse1;
  logic [7:0] car_cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  car_sensor_filter #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .sensor_in(sensor_in),
    .is_car(is_car), .car_pulse(car_pulse), .car_cnt(car_cnt)
  );

  car_sensor_filter #(.DB_CYCLES(DB1), .HOLD_CYCLES(HOLD1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst(rst), .sensor_in(sensor_in),
    .is_car(is_car1), .car_pulse(car_pulse1), .car_cnt(car_cnt1)
  );

  always #5 clk = ~clk;

  // Reference model in terms of run lengths of the synced level: the
  // debounced level flips once a run of the opposite value reaches DB; the
  // request then drops once the zero run reaches a hold deadline, which is
  // DB+HOLD after a debounced release and 1+HOLD after a short high glitch.
  typedef struct {
    logic       s1;
    logic       s2;
    logic       deb;
    logic       car;
    logic       pulse;
    logic [7:0] cnt;
    int         ones;
    int         zeros;
    int         hold_end;
  } model_t;

  model_t m0, m1;

  function automatic model_t model_next(input model_t m, input logic s,
                                        input logic r, input int db,
                                        input int hold);
    model_t n;
    logic   v;
    n = m;
    if (r) begin
      n = '{default: '0};
      return n;
    end
    v       = m.s2;
    n.s2    = m.s1;
    n.s1    = s;
    n.pulse = 1'b0;
    if (v) begin
      n.ones  = (m.ones < 1000000) ? m.ones + 1 : m.ones;
      n.zeros = 0;
    end else begin
      n.zeros = (m.zeros < 1000000) ? m.zeros + 1 : m.zeros;
      n.ones  = 0;
    end
    if (!m.deb && v && n.ones == db) begin
      n.deb   = 1'b1;
      n.car   = 1'b1;
      n.pulse = 1'b1;
      n.cnt   = (m.cnt == 8'd255) ? 8'd255 : m.cnt + 8'd1;
    end else if (m.deb && !v && n.zeros == db) begin
      n.deb      = 1'b0;
      n.hold_end = db + hold;
    end else if (!m.deb && m.car) begin
      if (v)
        n.hold_end = 1 + hold;
      else if (n.zeros == m.hold_end)
        n.car = 1'b0;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Apply one clock of stimulus, advance both models, compare both DUTs.
  task automatic step(input logic s, input logic r);
    sensor_in = s;
    rst       = r;
    @(posedge clk);
    m0 = model_next(m0, s, r, DB, HOLD);
    m1 = model_next(m1, s, r, DB1, HOLD1);
    #1;
    check("model_db4", {22'd0, is_car, car_pulse, car_cnt},
          {22'd0, m0.car, m0.pulse, m0.cnt});
    check("model_db1", {22'd0, is_car1, car_pulse1, car_cnt1},
          {22'd0, m1.car, m1.pulse, m1.cnt});
  endtask

  typedef struct {
    logic       r;
    logic       s;
    int         n;
    logic       e_car;
    logic       e_pulse;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t       tbl[11];
  logic [7:0] exp_cnt;
  logic       lvl;
  int         len;

  initial begin
    m0 = '{default: '0};
    m1 = '{default: '0};

    // Reset with sensor high, clean press, bouncy release, short glitch.
    tbl[0]  = '{1'b1, 1'b1,  2, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1,  5, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b1,  1, 1'b1, 1'b1, 8'd1};
    tbl[3]  = '{1'b0, 1'b1,  1, 1'b1, 1'b0, 8'd1};
    tbl[4]  = '{1'b0, 1'b1, 23, 1'b1, 1'b0, 8'd1};
    tbl[5]  = '{1'b0, 1'b0,  2, 1'b1, 1'b0, 8'd1};
    tbl[6]  = '{1'b0, 1'b1,  1, 1'b1, 1'b0, 8'd1};
    tbl[7]  = '{1'b0, 1'b0, 15, 1'b1, 1'b0, 8'd1};
    tbl[8]  = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 8'd1};
    tbl[9]  = '{1'b0, 1'b1,  3, 1'b0, 1'b0, 8'd1};
    tbl[10] = '{1'b0, 1'b0,  6, 1'b0, 1'b0, 8'd1};

    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < tbl[i].n; j++)
        step(tbl[i].s, tbl[i].r);
      check($sformatf("vec%0d", i), {22'd0, is_car, car_pulse, car_cnt},
            {22'd0, tbl[i].e_car, tbl[i].e_pulse, tbl[i].e_cnt});
    end

    // Re-arrival five cycles into HOLD: second pulse, request never drops.
    repeat (5) step(1'b1, 1'b0);
    check("t5_pre_arrival", {31'd0, is_car}, 32'd0);
    step(1'b1, 1'b0);
    check("t5_arrival", {22'd0, is_car, car_pulse, car_cnt}, {22'd0, 1'b1, 1'b1, 8'd2});
    repeat (4) step(1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b0);
      check("t5_hold_car", {31'd0, is_car}, 32'd1);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      check("t5_rearrive_car", {31'd0, is_car}, 32'd1);
    end
    check("t5_rearrive", {23'd0, car_pulse, car_cnt}, {23'd0, 1'b1, 8'd3});

    // Two-cycle glitch in HOLD: hold restarts, request falls 13 edges after
    // the glitch clears at the input pin.
    repeat (4) step(1'b1, 1'b0);
    repeat (11) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0);
      check("t5_glitch_hold", {22'd0, is_car, car_pulse, car_cnt}, {22'd0, 1'b1, 1'b0, 8'd3});
    end
    step(1'b0, 1'b0);
    check("t5_glitch_fall", {31'd0, is_car}, 32'd0);

    // Saturation: every arrival pulses, the count stops at 255.
    exp_cnt = 8'd3;
    for (int p = 0; p < 260; p++) begin
      repeat (5) step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
      check("t6_pulse", {23'd0, car_pulse, car_cnt}, {23'd0, 1'b1, exp_cnt});
      step(1'b0, 1'b0);
      check("t6_pulse_width", {31'd0, car_pulse}, 32'd0);
      repeat (5) step(1'b0, 1'b0);
    end
    check("t6_saturated", {24'd0, car_cnt}, 32'd255);

    // Reset during PRESENT clears everything; a held sensor requalifies.
    repeat (6) step(1'b1, 1'b0);
    check("t6_present", {31'd0, is_car}, 32'd1);
    step(1'b1, 1'b1);
    check("t6_reset", {22'd0, is_car, car_pulse, car_cnt}, 32'd0);
    repeat (5) step(1'b1, 1'b0);
    check("t6_requal_low", {31'd0, is_car}, 32'd0);
    step(1'b1, 1'b0);
    check("t6_requal", {22'd0, is_car, car_pulse, car_cnt}, {22'd0, 1'b1, 1'b1, 8'd1});

    // One-sample debounce: request rises on edge 3 after the input rises.
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("db1_before", {31'd0, is_car1}, 32'd0);
    step(1'b1, 1'b0);
    check("db1_rise", {22'd0, is_car1, car_pulse1, car_cnt1}, {22'd0, 1'b1, 1'b1, 8'd1});

    // Random bursts of short bounces and long holds, with rare resets.
    lvl = 1'b0;
    for (int k = 0; k < 250; k++) begin
      lvl = ~lvl;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30))
                                        : int'($urandom_range(1, 6));
      for (int j = 0; j < len; j++)
        step(lvl, ($urandom_range(0, 399) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
